// File: rtl/cpu_fetch_pkg.sv
// Shared types and default sizes for the instruction-fetch queue.
package cpu_fetch_pkg;

    localparam int unsigned FETCH_BITS     = 32;
    localparam int unsigned FETCH_DEPTH    = 4;
    localparam int unsigned FETCH_PTR_BITS = 2;

    typedef struct packed {
        logic [FETCH_BITS-1:0] pc;
        logic [FETCH_BITS-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetched instructions with clear, occupancy and a
// register-sourced head (zero while empty).
module fetch_fifo
    import cpu_fetch_pkg::*;
#(
    parameter int unsigned DEPTH    = FETCH_DEPTH,
    parameter int unsigned PTR_BITS = FETCH_PTR_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                push,
    input  fetch_entry_t        push_data,
    input  logic                pop,
    output fetch_entry_t        head,
    output logic                valid,
    output logic [PTR_BITS:0]   occupancy
);

    localparam int unsigned CW = PTR_BITS + 1;

    fetch_entry_t          mem [DEPTH];
    logic [PTR_BITS-1:0]   wr_ptr;
    logic [PTR_BITS-1:0]   rd_ptr;
    logic [CW-1:0]         count;
    logic                  do_push;
    logic                  do_pop;

    assign do_push = push & ~clear;
    assign do_pop  = pop & ~clear & (count != CW'(0));

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_BITS'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_BITS'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign valid     = (count != CW'(0));
    assign occupancy = count;
    assign head      = valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch stage: PC, credit-based imem requests, redirect flush
// and a tagged instruction FIFO toward decode. Optional FETCH_QUEUE_PERF_EN
// adds saturating performance counters.
module fetch_queue
    import cpu_fetch_pkg::*;
#(
    parameter int unsigned     BITS       = FETCH_BITS,
    parameter int unsigned     DEPTH      = FETCH_DEPTH,
    parameter int unsigned     PTR_BITS   = FETCH_PTR_BITS,
    parameter logic [BITS-1:0] RESET_ADDR = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                redirect,
    input  logic [BITS-1:0]     redirect_addr,
    input  logic                halt_fetch,
    output logic                imem_req,
    output logic [BITS-1:0]     imem_addr,
    input  logic [BITS-1:0]     imem_rdata,
    input  logic                id_stall,
    output logic                if_valid,
    output logic [BITS-1:0]     if_instr,
    output logic [BITS-1:0]     if_pc,
    output logic [BITS-1:0]     if_pc_plus1,
    output logic [PTR_BITS:0]   occupancy
`ifdef FETCH_QUEUE_PERF_EN
    ,
    output logic [31:0]         perf_empty_cycles,
    output logic [15:0]         perf_flush_count,
    output logic [31:0]         perf_stall_cycles
`endif
);

    localparam int unsigned CW = PTR_BITS + 2;

    logic [BITS-1:0]   pc;
    logic [BITS-1:0]   pc_tag;
    logic              inflight;
    logic [CW-1:0]     credit_used;
    logic              push;
    logic              pop;
    fetch_entry_t      push_data;
    fetch_entry_t      head;

    // Entries queued plus the response still in flight must fit the FIFO.
    assign credit_used = CW'(occupancy) + CW'(inflight);
    assign imem_req    = ~rst & ~redirect & ~halt_fetch & (credit_used < CW'(DEPTH));
    assign imem_addr   = pc;

    assign push      = inflight & ~redirect;
    assign pop       = if_valid & ~id_stall & ~redirect;
    assign push_data = '{pc: FETCH_BITS'(pc_tag), instr: FETCH_BITS'(imem_rdata)};

    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_ADDR;
            pc_tag   <= '0;
            inflight <= 1'b0;
        end else if (redirect) begin
            pc       <= redirect_addr;
            inflight <= 1'b0;
        end else begin
            inflight <= imem_req;
            if (imem_req) begin
                pc     <= pc + BITS'(1);
                pc_tag <= pc;
            end
        end
    end

    fetch_fifo #(
        .DEPTH     (DEPTH),
        .PTR_BITS  (PTR_BITS)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (redirect),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .valid     (if_valid),
        .occupancy (occupancy)
    );

    assign if_instr    = BITS'(head.instr);
    assign if_pc       = BITS'(head.pc);
    assign if_pc_plus1 = if_valid ? (if_pc + BITS'(1)) : '0;

`ifdef FETCH_QUEUE_PERF_EN
    logic flush_hit;

    assign flush_hit = redirect & ((occupancy != '0) | inflight);

    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_empty_cycles <= '0;
            perf_flush_count  <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (~if_valid & ~halt_fetch & ~(&perf_empty_cycles)) begin
                perf_empty_cycles <= perf_empty_cycles + 32'(1);
            end
            if (flush_hit & ~(&perf_flush_count)) begin
                perf_flush_count <= perf_flush_count + 16'(1);
            end
            if (if_valid & id_stall & ~(&perf_stall_cycles)) begin
                perf_stall_cycles <= perf_stall_cycles + 32'(1);
            end
        end
    end
`endif

endmodule
